// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-line input and received-word output bundle for uart_rx
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_tick;
  logic                 i_rx;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_rx_done;
  logic                 o_frame_err;
  logic                 o_parity_err;
  modport master (output i_tick, i_rx, input o_data, o_rx_done, o_frame_err, o_parity_err);
  modport slave  (input i_tick, i_rx, output o_data, o_rx_done, o_frame_err, o_parity_err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, mid-bit sampling, LSB first; parity stage enabled by UART_RX_PARITY_EN
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input logic      i_clock,
  input logic      i_reset,
  uart_rx_if.slave bus
);
  localparam int NW = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
  logic par;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t               state, state_n;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [4:0]           s_cnt;
  logic [NW-1:0]        n_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 mid_start, bit_end, last_bit, stop_end, perr;
  assign rx_s = sync[1];
  // two-flop synchronizer on the asynchronous line; resets to the idle level
  always_ff @(posedge i_clock) sync <= !i_reset ? 2'b11 : {sync[0], bus.i_rx};
  // state register
  always_ff @(posedge i_clock) state <= !i_reset ? IDLE : state_n;
  // next-state logic; the idle exit is level-driven and does not wait for a tick
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = rx_s ? IDLE : START;
      START:  if (mid_start) state_n = rx_s ? IDLE : DATA;
      DATA:   if (bit_end && last_bit) state_n = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_end) state_n = STOP;
`endif
      STOP:   if (stop_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // output decode: tick-qualified counter terminal values and the parity check
  always_comb begin
    mid_start = bus.i_tick && s_cnt == 5'd7;
    bit_end   = bus.i_tick && s_cnt == 5'd15;
    last_bit  = n_cnt == NW'(DATA_BITS - 1);
    stop_end  = state == STOP && bus.i_tick && s_cnt == 5'(SB_TICK - 1);
`ifdef UART_RX_PARITY_EN
    perr      = ^{shreg, par, PARITY_ODD[0]};
`else
    perr      = 1'b0;
`endif
  end
  // tick counter, bit index and shift register (samples enter at the MSB)
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      s_cnt <= '0;
      n_cnt <= '0;
      shreg <= '0;
`ifdef UART_RX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:   s_cnt <= '0;
        START:  if (bus.i_tick) begin
          s_cnt <= mid_start ? '0 : s_cnt + 5'd1;
          n_cnt <= '0;
        end
        DATA:   if (bus.i_tick) begin
          s_cnt <= bit_end ? '0 : s_cnt + 5'd1;
          if (bit_end) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            n_cnt <= last_bit ? n_cnt : n_cnt + NW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (bus.i_tick) begin
          s_cnt <= bit_end ? '0 : s_cnt + 5'd1;
          if (bit_end) par <= rx_s;
        end
`endif
        STOP:   if (bus.i_tick) s_cnt <= s_cnt + 5'd1;
        default: s_cnt <= '0;
      endcase
    end
  end
  // registered outputs, refreshed together with the one-cycle done strobe
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      bus.o_rx_done    <= 1'b0;
      bus.o_data       <= '0;
      bus.o_frame_err  <= 1'b0;
      bus.o_parity_err <= 1'b0;
    end else begin
      bus.o_rx_done <= stop_end;
      if (stop_end) begin
        bus.o_data       <= shreg;
        bus.o_frame_err  <= !rx_s;
        bus.o_parity_err <= perr;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and randomized frames checked against a word-level scoreboard
module tb_uart_rx;
  localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int BIT   = 64;
  localparam int FRAME = (DB + 2 + PB) * BIT;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;
  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  exp_t q[$];
  int   done_cyc[$];
  vec_t tbl[8];
  uart_rx_if #(.DATA_BITS(DB)) bus();
  uart_rx #(.DATA_BITS(DB), .SB_TICK(16), .PARITY_ODD(0)) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // baud generator stand-in: one tick every 4 clocks
  initial begin
    int phase = 0;
    bus.i_tick = 1'b0;
    forever begin
      @(negedge clk);
      bus.i_tick = (phase == 3);
      phase = (phase + 1) % 4;
    end
  end
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  // expected word from the frame contents: data as sent, framing error when
  // the stop bit is low, even parity mismatch when the parity stage exists
  function automatic exp_t model(logic [7:0] d, logic stop, logic par);
    exp_t e;
    e.data = d;
    e.ferr = !stop;
    e.perr = (PB == 1) ? (^d ^ par) : 1'b0;
    return e;
  endfunction
  // scoreboard: every strobe must match the oldest outstanding frame
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.o_rx_done) begin
        done_cyc.push_back(cyc);
        check("done_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("data", bus.o_data, e.data);
          check("frame_err", bus.o_frame_err, e.ferr);
          check("parity_err", bus.o_parity_err, e.perr);
        end
      end
    end
  end
  task automatic drive(logic v, int n);
    bus.i_rx = v;
    repeat (n) @(negedge clk);
  endtask
  // a low stop bit is held through its sampling point, then released so the
  // receiver's level-sensitive restart sees idle at its mid-start check
  task automatic send_frame(logic [7:0] d, logic stop, logic par);
    drive(1'b0, BIT);
    for (int i = 0; i < DB; i++) drive(d[i], BIT);
    if (PB == 1) drive(par, BIT);
    if (stop) drive(1'b1, BIT);
    else begin
      drive(1'b0, 48);
      drive(1'b1, 16);
    end
  endtask
  initial begin
    logic [7:0] d;
    logic       stop, par;
    int         gap;
    tbl[0] = '{8'h55, 1'b1, 1'b0, 20, 8'h55, 1'b0, 1'b0};
    tbl[1] = '{8'hA3, 1'b0, 1'b0, 80, 8'hA3, 1'b1, 1'b0};
    tbl[2] = '{8'h07, 1'b1, 1'b1, 10, 8'h07, 1'b0, 1'b0};
    tbl[3] = '{8'h07, 1'b1, 1'b0, 10, 8'h07, 1'b0, 1'(PB)};
    tbl[4] = '{8'h80, 1'b1, 1'b1, 0,  8'h80, 1'b0, 1'b0};
    tbl[5] = '{8'h01, 1'b1, 1'b1, 30, 8'h01, 1'b0, 1'b0};
    tbl[6] = '{8'hFF, 1'b0, 1'b0, 70, 8'hFF, 1'b1, 1'b0};
    tbl[7] = '{8'h3C, 1'b1, 1'b0, 20, 8'h3C, 1'b0, 1'b0};
    bus.i_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", bus.o_data, 0);
    check("reset_done", bus.o_rx_done, 0);
    check("reset_frame_err", bus.o_frame_err, 0);
    check("reset_parity_err", bus.o_parity_err, 0);
    rst_n = 1'b1;
    drive(1'b1, 20);
    for (int i = 0; i < 8; i++) begin
      q.push_back('{tbl[i].exp_data, tbl[i].exp_ferr, tbl[i].exp_perr});
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].par);
      drive(1'b1, tbl[i].gap + 8);
      check("pending_after_table", q.size(), 0);
    end
    drive(1'b0, 20);
    drive(1'b1, 200);
    check("pending_after_glitch", q.size(), 0);
    q.push_back(model(8'h3C, 1'b1, 1'b0));
    send_frame(8'h3C, 1'b1, 1'b0);
    drive(1'b1, 20);
    check("pending_after_3c", q.size(), 0);
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(i[0], BIT);
    drive(1'b1, 32);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_data", bus.o_data, 0);
    check("midreset_done", bus.o_rx_done, 0);
    check("midreset_frame_err", bus.o_frame_err, 0);
    check("midreset_parity_err", bus.o_parity_err, 0);
    rst_n = 1'b1;
    drive(1'b1, FRAME);
    check("no_strobe_after_reset", q.size(), 0);
    q.push_back(model(8'h0F, 1'b1, 1'b0));
    send_frame(8'h0F, 1'b1, 1'b0);
    drive(1'b1, 20);
    check("pending_after_0f", q.size(), 0);
    done_cyc.delete();
    q.push_back(model(8'h00, 1'b1, 1'b0));
    q.push_back(model(8'hFF, 1'b1, 1'b0));
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    drive(1'b1, 100);
    check("b2b_strobes", done_cyc.size(), 2);
    if (done_cyc.size() == 2) check("b2b_spacing", done_cyc[1] - done_cyc[0], FRAME);
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = $urandom_range(0, 4) != 0;
      par  = 1'($urandom_range(0, 1));
      gap  = stop ? int'($urandom_range(0, 40)) : 64 + int'($urandom_range(0, 40));
      q.push_back(model(d, stop, par));
      send_frame(d, stop, par);
      drive(1'b1, gap);
    end
    drive(1'b1, 100);
    check("pending_after_random", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive stage sitting directly downstream of the 16x oversampling baud tick generator. Samples the serial line on each `i_tick`, detects and validates the start bit, recovers `DATA_BITS` data bits LSB-first at mid-bit, and checks the stop bit. Delivers each received word with a one-cycle done strobe and a framing-error flag to the receive FIFO or interface logic.

## Interface
- `DATA_BITS`, 8: data bits per frame, minimum 5, maximum 9.
- `SB_TICK`, 16: ticks spent in the stop bit. Use 16 for 1 stop bit, 24 for 1.5 and 32 for 2.
- `PARITY_ODD`, 0: parity sense, used only when parity is compiled in. 0 selects even parity, 1 selects odd.
- `i_clock`  in  1  system clock; all logic is on the rising edge.
- `i_reset`  in  1  reset, synchronous and active-low.
- `i_tick`  in  1  oversampling strobe from the baud generator; one-cycle pulse at 16x baud.
- `i_rx`  in  1  asynchronous serial line; idles high.
- `o_data`  out  DATA_BITS  last received word, held until the next done strobe.
- `o_rx_done`  out  1  one-cycle strobe: `o_data`, `o_frame_err` and `o_parity_err` are updated this cycle.
- `o_frame_err`  out  1  stop bit was sampled low in the last frame.
- `o_parity_err`  out  1  parity mismatch in the last frame; tied to 0 when parity is compiled out.

## Operation
- **Synchronizer:** `i_rx` passes through a 2-FF synchronizer (both FFs reset to 1). All FSM decisions use the synchronized value `rx_s`.
- **Counters:**
  - `s_cnt`, 5 bits: counts ticks; advances only on cycles with `i_tick` high.
  - `n_cnt`: bit index, width `$clog2(DATA_BITS)`.
  - Shift register: `DATA_BITS` wide; each sample enters at the MSB and the register shifts right, so bit 0 ends up in `o_data[0]`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** when `rx_s` is 0, go to START and set `s_cnt` to 0. This transition does not wait for a tick.
  - **START:** on a tick with `s_cnt` = 7 (mid start bit):
    - `rx_s` = 0: go to DATA; set `s_cnt` and `n_cnt` to 0.
    - `rx_s` = 1: glitch; go to IDLE with no strobe.
    - On any other tick, increment `s_cnt`.
  - **DATA:** on a tick with `s_cnt` = 15:
    - Set `s_cnt` to 0 and shift in `rx_s`.
    - If `n_cnt` = `DATA_BITS`-1, go to PARITY (parity compiled in) or STOP (compiled out).
    - Otherwise increment `n_cnt`.
  - **PARITY:** on a tick with `s_cnt` = 15, latch `rx_s` as the parity bit, set `s_cnt` to 0 and go to STOP.
  - **STOP:** on a tick with `s_cnt` = `SB_TICK`-1:
    - Load `o_data` from the shift register.
    - Set `o_frame_err` to the inverse of `rx_s`.
    - Set `o_parity_err`.
    - Pulse `o_rx_done`.
    - Go to IDLE.
- **Parity check:** `o_parity_err` = XOR of the data bits, the parity bit and `PARITY_ODD`.
- **Reporting:** `o_frame_err` and `o_parity_err` do not suppress `o_rx_done`; the word is always delivered.
- **Absent ticks:** if `i_tick` stays low, the FSM holds its state indefinitely; there is no timeout.

## Timing
- **Reset values** (`i_reset` low at a rising edge):
  - State IDLE; `s_cnt`, `n_cnt` and shift register 0.
  - `o_data` = 0, `o_rx_done` = 0, `o_frame_err` = 0, `o_parity_err` = 0.
  - Synchronizer FFs = 1.
- **Reset mid-frame:** same values as above. The partial frame is discarded with no strobe.
- **Synchronizer latency:** 2 clocks from an `i_rx` edge to `rx_s`.
- **Outputs:** all registered. `o_rx_done` is high for exactly the one cycle after the edge where the final STOP tick is sampled, and `o_data` is valid in that same cycle.
- **Back-to-back frames:** a start bit directly after the stop bit is accepted. The FSM is back in IDLE on the cycle `o_rx_done` is high, so the next falling edge is detected.
- **Tick and line edge in the same cycle:** the IDLE→START transition happens, and that tick is not counted.
- **Simultaneous reset and tick:** reset wins.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- **Defined:** the PARITY state exists; the frame is start, `DATA_BITS` data bits, parity, stop; `o_parity_err` is computed as in Operation.
- **Undefined:** the PARITY state and parity logic are absent; DATA goes directly to STOP; `o_parity_err` is constant 0.

## Test plan
Test conditions: bench drives `i_tick` every 4 clocks, so one bit lasts 64 clocks; `DATA_BITS` = 8 and `SB_TICK` = 16 unless noted.

- **Clean frame:** frame 0x55 with stop = 1 → exactly one `o_rx_done` pulse, `o_data` = 0x55, `o_frame_err` = 0.
- **Start-bit glitch:** `i_rx` low for 20 clocks then high → no `o_rx_done`; FSM back in IDLE; a following frame 0x3C is received correctly.
- **Framing error:** frame 0xA3 with stop bit driven 0 → `o_rx_done` pulses, `o_data` = 0xA3, `o_frame_err` = 1.
- **Reset mid-frame:** `i_reset` low for one cycle during data bit 4 → next cycle all outputs 0 and state IDLE; a subsequent frame 0x0F gives `o_data` = 0x0F with no spurious strobe.
- **Back-to-back frames:** 0x00 then 0xFF with zero idle time → two `o_rx_done` pulses 640 clocks apart, data 0x00 then 0xFF, no errors.
- **Parity (macro defined, `PARITY_ODD` = 0):** frame 0x07 with parity bit 1 → `o_parity_err` = 0; same frame with parity bit 0 → `o_parity_err` = 1 and `o_data` = 0x07.
